// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types and constants for the fetch sequencer.
//   seqStateT : sequencer FSM encoding (PAUSE only reachable with FETCH_SEQ_STEP_EN)
//   OP_*      : accumulator CPU opcode nibbles
//   IR_RST_OP : opcode held in IR after reset (STP, so no writes are requested)
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    PAUSE  = 3'd5
  } seqStateT;

  localparam logic [3:0] OP_CLA = 4'd0;
  localparam logic [3:0] OP_COM = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_CSL = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_STA = 4'd5;
  localparam logic [3:0] OP_LDA = 4'd6;
  localparam logic [3:0] OP_STP = 4'd15;

  localparam logic [3:0] IR_RST_OP = OP_STP;

endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: program memory read channel.
//   memReq  : read request (sequencer -> memory)
//   memAddr : read address (sequencer -> memory)
//   memAck  : data valid   (memory -> sequencer)
//   memData : instruction word (memory -> sequencer)
// master = sequencer side, slave = memory side.
interface fetch_seq_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [DATA_W-1:0] memData;

  modport master (output memReq, memAddr, input memAck, memData);
  modport slave  (input memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/fetch_seq_pc.sv
// fetch_seq_pc: program counter register.
//   iClk/iRst : clock, async active-high reset (PC -> 0)
//   iClr      : synchronous load of zero
//   iInc      : advance by one; wraps modulo 2^ADDR_W with no flag
//   oPC       : current PC
module fetch_seq_pc #(
  parameter int ADDR_W = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iClr,
  input  logic              iInc,
  output logic [ADDR_W-1:0] oPC
);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)      oPC <= '0;
    else if (iClr) oPC <= '0;
    else if (iInc) oPC <= oPC + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer for the accumulator CPU.
//   iClk, iRst : clock, async active-high reset
//   iStart     : start / resume from IDLE or HALT (level)
//   mem        : program memory read channel (fetch_seq_if.master)
//   oInst      : opcode nibble from IR to decoder
//   oAddr      : operand address from IR to datapath
//   oExec      : one-cycle execute strobe
//   iStop      : decoder stop, sampled only at the end of EXEC
//   oPC        : current program counter
//   oHalt      : sequencer is in HALT
//   iStep      : single-step advance (only with FETCH_SEQ_STEP_EN)
// Build option: define FETCH_SEQ_STEP_EN to pause after every non-stop
// instruction until a rising edge of iStep.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  fetch_seq_if.master       mem,
  output logic [3:0]        oInst,
  output logic [ADDR_W-1:0] oAddr,
  output logic              oExec,
  input  logic              iStop,
  output logic [ADDR_W-1:0] oPC,
  output logic              oHalt
`ifdef FETCH_SEQ_STEP_EN
  ,
  input  logic              iStep
`endif
);

  seqStateT state, stateNext;
  logic     ackTake;

  // Ack only counts while we are actually requesting.
  assign ackTake = (state == FETCH) && mem.memAck;

  // Request/address are decoded so a reset drops the request immediately.
  assign mem.memReq  = (state == FETCH);
  assign mem.memAddr = oPC;

`ifdef FETCH_SEQ_STEP_EN
  // Previous iStep level: advancing only on a 0->1 change means a held
  // level yields one instruction, not a free run.
  logic stepQ;
  logic stepRise;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) stepQ <= 1'b0;
    else      stepQ <= iStep;
  end

  assign stepRise = iStep && !stepQ;
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (iStart) stateNext = FETCH;
      FETCH:  if (mem.memAck) stateNext = DECODE;
      DECODE: stateNext = EXEC;
`ifdef FETCH_SEQ_STEP_EN
      EXEC:   stateNext = iStop ? HALT : PAUSE;
      PAUSE:  if (stepRise) stateNext = FETCH;
`else
      EXEC:   stateNext = iStop ? HALT : FETCH;
`endif
      HALT:   if (iStart) stateNext = FETCH;
      default: stateNext = IDLE;
    endcase
  end

  // Instruction register drives the decoder/datapath fields directly.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oInst <= IR_RST_OP;
      oAddr <= '0;
    end else if (ackTake) begin
      oInst <= mem.memData[DATA_W-1 -: 4];
      oAddr <= mem.memData[ADDR_W-1:0];
    end
  end

  // Strobes registered from the next state so they coincide with the state.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oExec <= 1'b0;
      oHalt <= 1'b0;
    end else begin
      oExec <= (stateNext == EXEC);
      oHalt <= (stateNext == HALT);
    end
  end

  fetch_seq_pc #(.ADDR_W(ADDR_W)) uPc (
    .iClk (iClk),
    .iRst (iRst),
    .iClr (state == IDLE),
    .iInc (ackTake),
    .oPC  (oPC)
  );

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              iClk = 1'b0;
  logic              iRst = 1'b1;
  logic              iStart = 1'b0;
  logic              iStop = 1'b0;
  logic [3:0]        oInst;
  logic [ADDR_W-1:0] oAddr;
  logic              oExec;
  logic [ADDR_W-1:0] oPC;
  logic              oHalt;
`ifdef FETCH_SEQ_STEP_EN
  logic              iStep = 1'b0;
`endif

  fetch_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

  fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .mem    (mem),
    .oInst  (oInst),
    .oAddr  (oAddr),
    .oExec  (oExec),
    .iStop  (iStop),
    .oPC    (oPC),
    .oHalt  (oHalt)
`ifdef FETCH_SEQ_STEP_EN
    ,
    .iStep  (iStep)
`endif
  );

  always #5 iClk = ~iClk;

  // Memory model: per-address ack latency counted in request cycles.
  logic [7:0] rom [16];
  int         delay [16];
  int         reqCyc = 0;
  logic       ackNoise = 1'b0;
  int         cyc = 0;

  always @(posedge iClk) begin
    cyc    <= cyc + 1;
    reqCyc <= (mem.memReq && !mem.memAck) ? reqCyc + 1 : 0;
  end

  assign mem.memAck  = (mem.memReq && (reqCyc >= delay[mem.memAddr])) || ackNoise;
  assign mem.memData = rom[mem.memAddr];

  // Decoder stop: the STP opcode asserts stop while it executes.
  logic stopNoise = 1'b0;
  always_comb iStop = (oExec && oInst == OP_STP) || stopNoise;

  typedef struct {
    logic [3:0] inst;
    logic [3:0] addr;
    logic [3:0] pc;
  } expT;

  expT sb[$];
  int  execLog[$];
  int  ackLog[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [3:0] inst, input logic [3:0] addr, input logic [3:0] pc);
    expT e;
    e.inst = inst; e.addr = addr; e.pc = pc;
    sb.push_back(e);
  endfunction

  // Monitor: every execute strobe consumes one expected instruction.
  always @(negedge iClk) begin
    if (oExec) begin
      execLog.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL execUnexpected: got oExec=1 inst=%0h pc=%0h expected no execute (t=%0t)", oInst, oPC, $time);
      end else begin
        expT e;
        e = sb.pop_front();
        check("execInst", oInst, e.inst);
        check("execAddr", oAddr, e.addr);
        check("execPC", oPC, e.pc);
      end
    end
    if (mem.memReq && mem.memAck) ackLog.push_back(int'(mem.memAddr));
  end

  task automatic doReset();
    iRst = 1'b1; iStart = 1'b0; ackNoise = 1'b0; stopNoise = 1'b0;
`ifdef FETCH_SEQ_STEP_EN
    iStep = 1'b0;
`endif
    @(negedge iClk); @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic waitHalt(input int budget);
    int n = 0;
    while (!oHalt && n < budget) begin
      @(negedge iClk);
      n++;
    end
    check("haltReached", oHalt, 1);
  endtask

  task automatic waitFetchAt(input logic [3:0] a, input int budget);
    int n = 0;
    while (!(mem.memReq && mem.memAddr == a) && n < budget) begin
      @(negedge iClk);
      n++;
    end
    check("fetchReached", {mem.memReq, mem.memAddr}, {1'b1, a});
  endtask

  task automatic clearLogs();
    execLog.delete();
    ackLog.delete();
  endtask

  task automatic loadProg3();
    for (int i = 0; i < 16; i++) begin rom[i] = 8'hF0; delay[i] = 0; end
    rom[0] = 8'h40; rom[1] = 8'h53; rom[2] = 8'hF0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    loadProg3();

    // ---- reset values and basic 3-instruction program, zero wait ----
    doReset();
    check("rstMemReq", mem.memReq, 0);
    check("rstExec", oExec, 0);
    check("rstHalt", oHalt, 0);
    check("rstInst", oInst, 4'hF);
    check("rstAddr", oAddr, 0);
    check("rstPC", oPC, 0);
    clearLogs();
    push(4'h4, 4'h0, 4'h1);
    push(4'h5, 4'h3, 4'h2);
    push(4'hF, 4'h0, 4'h3);
    pulseStart();
    waitHalt(40);
    check("t1PC", oPC, 3);
    check("t1SbEmpty", sb.size(), 0);
    check("t1ExecCount", execLog.size(), 3);
    if (execLog.size() == 3) begin
      check("t1Gap0", execLog[1] - execLog[0], 3);
      check("t1Gap1", execLog[2] - execLog[1], 3);
    end
    check("t1AckCount", ackLog.size(), 3);
    if (ackLog.size() == 3) begin
      check("t1Addr0", ackLog[0], 0);
      check("t1Addr1", ackLog[1], 1);
      check("t1Addr2", ackLog[2], 2);
    end

    // ---- ack/stop noise while halted: nothing moves ----
    for (int i = 0; i < 12; i++) begin
      ackNoise  = 1'($urandom_range(0, 1));
      stopNoise = 1'($urandom_range(0, 1));
      @(negedge iClk);
      check("haltNoiseHalt", oHalt, 1);
      check("haltNoiseReq", mem.memReq, 0);
      check("haltNoisePC", oPC, 3);
    end
    ackNoise = 1'b0; stopNoise = 1'b0;

    // ---- noise in IDLE after reset ----
    doReset();
    for (int i = 0; i < 8; i++) begin
      ackNoise  = 1'($urandom_range(0, 1));
      stopNoise = 1'($urandom_range(0, 1));
      @(negedge iClk);
      check("idleNoiseReq", mem.memReq, 0);
      check("idleNoisePC", oPC, 0);
      check("idleNoiseHalt", oHalt, 0);
    end
    ackNoise = 1'b0; stopNoise = 1'b0;

    // ---- two wait cycles on address 1 ----
    doReset();
    delay[1] = 2;
    clearLogs();
    push(4'h4, 4'h0, 4'h1);
    push(4'h5, 4'h3, 4'h2);
    push(4'hF, 4'h0, 4'h3);
    pulseStart();
    waitFetchAt(4'h1, 20);
    for (int k = 0; k < 3; k++) begin
      check("waitReq", mem.memReq, 1);
      check("waitAddr", mem.memAddr, 1);
      check("waitIRHeld", oInst, 4'h4);
      check("waitAck", mem.memAck, (k == 2) ? 1 : 0);
      @(negedge iClk);
    end
    waitHalt(40);
    check("t2PC", oPC, 3);
    check("t2SbEmpty", sb.size(), 0);
    check("t2ExecCount", execLog.size(), 3);
    if (execLog.size() == 3) begin
      check("t2Gap0", execLog[1] - execLog[0], 5);
      check("t2Gap1", execLog[2] - execLog[1], 3);
    end
    delay[1] = 0;

    // ---- async reset mid-FETCH, then a late ack ----
    doReset();
    delay[1] = 15;
    clearLogs();
    push(4'h4, 4'h0, 4'h1);
    pulseStart();
    waitFetchAt(4'h1, 20);
    check("preRstInst", oInst, 4'h4);
    check("preRstPC", oPC, 1);
    #2;
    iRst = 1'b1;
    #1;
    check("rstAsyncReq", mem.memReq, 0);
    check("rstAsyncInst", oInst, 4'hF);
    check("rstAsyncAddr", oAddr, 0);
    check("rstAsyncPC", oPC, 0);
    @(negedge iClk);
    iRst = 1'b0;
    ackNoise = 1'b1;
    @(negedge iClk); @(negedge iClk);
    ackNoise = 1'b0;
    check("lateAckReq", mem.memReq, 0);
    check("lateAckInst", oInst, 4'hF);
    check("lateAckPC", oPC, 0);
    check("lateAckSbEmpty", sb.size(), 0);
    delay[1] = 0;
    // Restart proves the sequencer was back in IDLE at PC 0.
    clearLogs();
    push(4'h4, 4'h0, 4'h1);
    push(4'h5, 4'h3, 4'h2);
    push(4'hF, 4'h0, 4'h3);
    pulseStart();
    waitHalt(40);
    check("t3RestartAddr0", (ackLog.size() > 0) ? ackLog[0] : -1, 0);
    check("t3SbEmpty", sb.size(), 0);

    // ---- PC wrap ----
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'hF0;
    doReset();
    clearLogs();
    push(4'hF, 4'h0, 4'h1);
    pulseStart();
    waitHalt(20);
    check("wrap1PC", oPC, 1);
    check("wrap1Execs", execLog.size(), 1);
    clearLogs();
    for (int a = 1; a < 16; a++) push(OP_CLA, 4'h0, 4'((a + 1) % 16));
    push(4'hF, 4'h0, 4'h1);
    pulseStart();
    waitHalt(80);
    check("wrap2PC", oPC, 1);
    check("wrap2SbEmpty", sb.size(), 0);
    check("wrap2Execs", execLog.size(), 16);
    if (ackLog.size() == 16) begin
      check("wrap2First", ackLog[0], 1);
      check("wrap2Last15", ackLog[14], 15);
      check("wrap2Wrap0", ackLog[15], 0);
    end else begin
      check("wrap2AckCount", ackLog.size(), 16);
    end

`ifdef FETCH_SEQ_STEP_EN
    // ---- single step ----
    loadProg3();
    rom[0] = 8'h10; rom[1] = 8'h20;
    doReset();
    clearLogs();
    push(4'h1, 4'h0, 4'h1);
    pulseStart();
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge iClk);
    check("stepFirstExec", sb.size(), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      check("pauseNoReq", mem.memReq, 0);
    end
    push(4'h2, 4'h0, 4'h2);
    iStep = 1'b1;
    @(negedge iClk);
    iStep = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge iClk);
    check("stepSbEmpty", sb.size(), 0);
    check("stepExecCount", execLog.size(), 2);
    check("stepPausedReq", mem.memReq, 0);
    check("stepPC", oPC, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
